// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the sequential carry-lookahead adder slice:
//   state_t      - control FSM states (IDLE, RUN, DONE)
//   DEF_WIDTH    - default operand width
//   DEF_GROUP    - default bits processed per cycle
//   cnt_width()  - chunk counter width, ceil(log2(nchunk)) with a floor of 1
// -----------------------------------------------------------------------------
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_GROUP = 4;

    // A single-chunk adder still needs a 1-bit counter so the index is legal.
    function automatic int cnt_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/seq_cla_adder_if.sv
// -----------------------------------------------------------------------------
// seq_cla_adder_if
// Operand-in / result-out handshake bundle for seq_cla_adder.
//   in_valid/in_ready   - operand handshake (a, b, cin)
//   out_valid/out_ready - result handshake (sum, cout, ovf)
//   ovf                 - present only when SEQ_CLA_OVF_EN is defined
// Modports: master = producer/consumer side, slave = the adder.
// -----------------------------------------------------------------------------
interface seq_cla_adder_if
    import cla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SEQ_CLA_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef SEQ_CLA_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef SEQ_CLA_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout
    );

endinterface

// File: rtl/basic_cell.sv
// -----------------------------------------------------------------------------
// Basic_Cell
// One-bit adder cell exposing propagate/generate for lookahead.
//   a, b - operand bits      c - carry in
//   p    - a ^ b             g - a & b        s - sum bit
// -----------------------------------------------------------------------------
module Basic_Cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic p,
    output logic g,
    output logic s
);
    assign p = a ^ b;
    assign g = a & b;
    assign s = p ^ c;
endmodule

// File: rtl/seq_cla_adder_cla_group.sv
// -----------------------------------------------------------------------------
// cla_group
// Single-level carry-lookahead unit over GROUP bit positions (combinational).
//   p, g  - per-bit propagate / generate from the cells
//   cin   - carry into the group
//   c     - carry into each cell (c[0] == cin)
//   cout  - carry out of the group
//   pg/gg - group propagate / group generate
// -----------------------------------------------------------------------------
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = DEF_GROUP
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    input  logic             cin,
    output logic [GROUP-1:0] c,
    output logic             cout,
    output logic             pg,
    output logic             gg
);
    logic [GROUP:0] carry_all;
    logic [GROUP:1] gen_all;

    // Every carry is written as a flat sum of products so the depth is one
    // AND-OR level regardless of position, rather than a ripple chain.
    always_comb begin
        logic term;
        term      = 1'b0;
        carry_all = '0;
        gen_all   = '0;
        carry_all[0] = cin;
        for (int i = 1; i <= GROUP; i++) begin
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & p[k];
                end
                gen_all[i] = gen_all[i] | term;
            end
            term = cin;
            for (int k = 0; k < i; k++) begin
                term = term & p[k];
            end
            carry_all[i] = gen_all[i] | term;
        end
    end

    assign c    = carry_all[GROUP-1:0];
    assign cout = carry_all[GROUP];
    assign gg   = gen_all[GROUP];
    assign pg   = &p;

endmodule

// File: rtl/seq_cla_adder.sv
// -----------------------------------------------------------------------------
// seq_cla_adder
// Multi-cycle WIDTH-bit adder: one GROUP-bit chunk per clock through GROUP
// Basic_Cell instances and one cla_group; chunk carry held in a register.
//   clk, rst - clock, synchronous active-high reset
//   bus      - seq_cla_adder_if.slave (operand in, result out)
// Optional feature macro: SEQ_CLA_OVF_EN adds the registered ovf output.
// WIDTH must be an integer multiple of GROUP.
// -----------------------------------------------------------------------------
module seq_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP
) (
    input  logic           clk,
    input  logic           rst,
    seq_cla_adder_if.slave bus
);
    localparam int NCHUNK = WIDTH / GROUP;
    localparam int CW     = cnt_width(NCHUNK);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry_reg, cout_reg;
    logic [CW-1:0]    idx;
    logic             capture, step, last, in_ready_c, out_valid_c;

    logic [GROUP-1:0] a_chunk, b_chunk, p_vec, g_vec, c_vec, s_chunk;
    logic             grp_cout, grp_p, grp_g, carry_nxt;

    assign last    = (idx == CW'(NCHUNK - 1));
    assign a_chunk = a_reg[int'(idx)*GROUP +: GROUP];
    assign b_chunk = b_reg[int'(idx)*GROUP +: GROUP];

    for (genvar gi = 0; gi < GROUP; gi++) begin : g_cell
        Basic_Cell u_cell (
            .a (a_chunk[gi]),
            .b (b_chunk[gi]),
            .c (c_vec[gi]),
            .p (p_vec[gi]),
            .g (g_vec[gi]),
            .s (s_chunk[gi])
        );
    end

    cla_group #(.GROUP(GROUP)) u_cla (
        .p    (p_vec),
        .g    (g_vec),
        .cin  (carry_reg),
        .c    (c_vec),
        .cout (grp_cout),
        .pg   (grp_p),
        .gg   (grp_g)
    );

    // Chunk-to-chunk carry in G/P form; identical to grp_cout.
    assign carry_nxt = grp_g | (grp_p & carry_reg);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        capture     = 1'b0;
        step        = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    capture   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are only meaningful after capture, so they carry no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx       <= '0;
        end else if (capture) begin
            carry_reg <= bus.cin;
            idx       <= '0;
        end else if (step) begin
            sum_reg[int'(idx)*GROUP +: GROUP] <= s_chunk;
            carry_reg <= carry_nxt;
            idx       <= idx + CW'(1);
            if (last) cout_reg <= grp_cout;
        end
    end

`ifdef SEQ_CLA_OVF_EN
    logic ovf_reg;

    // In the last chunk c_vec[GROUP-1] is the carry into the sign bit.
    always_ff @(posedge clk) begin
        if (rst)               ovf_reg <= 1'b0;
        else if (step && last) ovf_reg <= c_vec[GROUP-1] ^ grp_cout;
    end

    assign bus.ovf = ovf_reg;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;

endmodule

// File: doc/seq_cla_adder.md
# seq_cla_adder

Multi-cycle wide adder that adds two WIDTH-bit operands GROUP bits per clock. Each cycle it drives one chunk through GROUP `Basic_Cell` instances and a group lookahead carry unit, then registers the chunk sum and the group carry-out. It sits directly downstream of the basic cells and consumes their p/g/s outputs. Towards the rest of the datapath it is a valid/ready operand-in, result-out stage.

## Interface
- WIDTH, 32, operand and sum width; must be an integer multiple of GROUP.
- GROUP, 4, bits processed per cycle, equal to the number of `Basic_Cell` instances and the lookahead span.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operands a, b and cin are presented.
- in_ready  output  1  block accepts operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum, cout and ovf are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, a+b+cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow; present only with SEQ_CLA_OVF_EN.

## Operation
- NCHUNK = WIDTH/GROUP. A chunk counter of ceil(log2(NCHUNK)) bits, minimum 1, indexes the chunks.
- FSM has three states.
  - IDLE: in_ready=1. An input handshake (in_valid & in_ready) captures a, b and cin into internal registers, loads the carry register with cin, clears the counter and moves to RUN.
  - RUN: the cells take a_reg/b_reg bits [idx*GROUP +: GROUP]. cla_group computes the internal carries from the p/g values and the carry register. The cell s bits are written into sum_reg at the same slice. The carry register takes the group carry-out and idx increments. When idx==NCHUNK-1, the FSM moves to DONE and cout_reg takes the group carry-out.
  - DONE: out_valid=1. sum, cout and ovf are held stable until out_ready. An output handshake returns the FSM to IDLE.
- in_ready=0 in RUN and DONE. in_valid is ignored there. Changes on a, b and cin after capture have no effect.
- ovf = carry into bit WIDTH-1 XOR cout. It is registered in the last RUN cycle.
- sum and cout drive sum_reg and cout_reg directly. They are meaningful only while out_valid=1.
- rst in any state, including mid-RUN, aborts the operation.
  - Next cycle: FSM in IDLE; in_ready=1; out_valid=0; sum=0; cout=0; ovf=0; counter=0; carry register=0.

## Timing
- Operand accepted at the end of cycle 0.
- Cycles 1..NCHUNK are RUN. out_valid first goes high in cycle NCHUNK+1.
- Defaults give 8 RUN cycles, with out_valid first high in cycle 9.
- Throughput is at most one add per NCHUNK+2 cycles. Output handshake in cycle k gives in_ready=1 in cycle k+1. There is no same-cycle accept in DONE.
- With out_ready held low, out_valid and the result stay stable indefinitely.
- NCHUNK=1 (WIDTH=GROUP): exactly one RUN cycle; out_valid first high in cycle 2.
- Combinational path per cycle: one chunk only, meaning GROUP cells plus one lookahead level. No ripple across chunks.

## Configuration
- SEQ_CLA_OVF_EN defined: the ovf port and its register exist and behave as in Operation.
- SEQ_CLA_OVF_EN undefined: the ovf port is absent, there is no ovf register, and all other behaviour is identical.

## Structure
- Shared package `cla_pkg` holds:
  - FSM state enum {IDLE, RUN, DONE}.
  - Default WIDTH and GROUP constants.
  - Function computing the counter width.
- One sub-module, `cla_group`:
  - Inputs: GROUP-bit p, GROUP-bit g, carry-in.
  - Outputs: GROUP-bit carries (one per cell c input), group carry-out, group P and G.
  - Purely combinational.
- The adder instantiates GROUP `Basic_Cell` cells and one `cla_group`.

## Test plan
- 0x00000003 + 0x00000005, cin=0 -> sum=0x00000008, cout=0. out_valid first high exactly 9 cycles after the accepting edge.
- 0xFFFFFFFF + 0x00000000, cin=1 -> sum=0x00000000, cout=1. Carry propagates across all 8 chunks.
- 0x7FFFFFFF + 0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1 with SEQ_CLA_OVF_EN. Build without the macro: port absent, sum and cout unchanged.
- Backpressure and ignored input:
  - Hold out_ready=0 for 20 cycles after out_valid: result stable and in_ready=0 throughout.
  - Drive in_valid=1 with new operands during RUN and DONE: no capture.
  - Release out_ready: in_ready=1 in the next cycle.
- Assert rst in RUN cycle 4 -> next cycle IDLE, all outputs 0, in_ready=1. A fresh 0x12345678 + 0x11111111 then gives sum=0x23456789, cout=0.
- WIDTH=4, GROUP=4: 0xF + 0x1, cin=0 -> sum=0x0, cout=1, out_valid high in cycle 2. Back-to-back operations with out_ready=1 are accepted every NCHUNK+2 cycles.
